// File: rtl/reg_dump_pkg.sv
// Shared types and sizes for the register-file dump engine.
// REG_DUMP_CHECKSUM_EN adds the SUM state (trailing checksum beat).
package reg_dump_pkg;

  localparam int REG_IDX_W    = 5;
  localparam int NUM_REGS_DEF = 32;
  localparam int XLEN_DEF     = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HALT = 3'd1,
    READ = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
`ifdef REG_DUMP_CHECKSUM_EN
    ,
    SUM  = 3'd5
`endif
  } dump_state_t;

endpackage

// File: rtl/reg_dump_if.sv
// Valid/ready beat stream carrying dumped register values.
// REG_DUMP_CHECKSUM_EN adds out_is_sum to mark the checksum beat.
interface reg_dump_if
  import reg_dump_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_data;
  logic [REG_IDX_W-1:0] out_idx;
  logic                 out_last;
`ifdef REG_DUMP_CHECKSUM_EN
  logic                 out_is_sum;
`endif

  modport master (
    output out_valid, out_data, out_idx, out_last,
`ifdef REG_DUMP_CHECKSUM_EN
    output out_is_sum,
`endif
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_idx, out_last,
`ifdef REG_DUMP_CHECKSUM_EN
    input  out_is_sum,
`endif
    output out_ready
  );
endinterface

// File: rtl/reg_dump_unit.sv
// Halts the core, walks a register range through a read port and streams it out.
// REG_DUMP_CHECKSUM_EN appends a modulo-2^XLEN checksum beat after the last register.
module reg_dump_unit
  import reg_dump_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int XLEN     = XLEN_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [REG_IDX_W-1:0] first_reg,
  input  logic [REG_IDX_W-1:0] last_reg,
  output logic                 halt_req,
  input  logic                 halt_ack,
  output logic [REG_IDX_W-1:0] rf_addr,
  input  logic [XLEN-1:0]      rf_data,
  output logic                 busy,
  output logic                 done,
  reg_dump_if.master           dump
);

  localparam int unsigned LAST_IDX = NUM_REGS - 1;

  dump_state_t          state_r, state_s;
  logic [REG_IDX_W-1:0] idx_r, last_r;
  logic [XLEN-1:0]      out_data_r;
  logic [REG_IDX_W-1:0] out_idx_r;
  logic                 out_last_r, out_valid_r, halt_req_r, busy_r, done_r;
  logic                 range_ok_s, idx_last_s, fire_s;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [XLEN-1:0]      sum_r;
  logic                 out_is_sum_r;
`endif

  assign range_ok_s = (first_reg <= last_reg) && (32'(last_reg) <= LAST_IDX);
  assign idx_last_s = (idx_r == last_r);
  assign fire_s     = out_valid_r && dump.out_ready;

  // Next-state logic for the dump sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (range_ok_s) state_s = HALT;
          else            state_s = DONE;
        end else begin
          state_s = IDLE;
        end
      end
      HALT: begin
        if (halt_ack) state_s = READ;
        else          state_s = HALT;
      end
      READ: state_s = SEND;
      SEND: begin
        if (fire_s) begin
`ifdef REG_DUMP_CHECKSUM_EN
          if (idx_last_s) state_s = SUM;
`else
          if (idx_last_s) state_s = DONE;
`endif
          else            state_s = READ;
        end else begin
          state_s = SEND;
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      SUM: begin
        if (fire_s) state_s = DONE;
        else        state_s = SUM;
      end
`endif
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, index, captured beat and flag registers; flags follow the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      idx_r        <= '0;
      last_r       <= '0;
      out_data_r   <= '0;
      out_idx_r    <= '0;
      out_last_r   <= 1'b0;
      out_valid_r  <= 1'b0;
      halt_req_r   <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      sum_r        <= '0;
      out_is_sum_r <= 1'b0;
`endif
    end else begin
      state_r     <= state_s;
`ifdef REG_DUMP_CHECKSUM_EN
      halt_req_r  <= (state_s == HALT) || (state_s == READ) || (state_s == SEND) || (state_s == SUM);
      out_valid_r <= (state_s == SEND) || (state_s == SUM);
`else
      halt_req_r  <= (state_s == HALT) || (state_s == READ) || (state_s == SEND);
      out_valid_r <= (state_s == SEND);
`endif
      busy_r      <= (state_s != IDLE);
      done_r      <= (state_s == DONE);

      if (state_r == IDLE && start) begin
        idx_r  <= first_reg;
        last_r <= last_reg;
      end else if (state_r == SEND && fire_s && !idx_last_s) begin
        idx_r <= idx_r + 5'd1;
      end

      if (state_r == READ) begin
        out_data_r <= rf_data;
        out_idx_r  <= idx_r;
`ifdef REG_DUMP_CHECKSUM_EN
        // The checksum beat, not the last register, carries out_last.
        out_last_r   <= 1'b0;
        out_is_sum_r <= 1'b0;
        sum_r        <= sum_r + rf_data;
`else
        out_last_r <= idx_last_s;
`endif
      end
`ifdef REG_DUMP_CHECKSUM_EN
      else if (state_r == SEND && fire_s && idx_last_s) begin
        out_data_r   <= sum_r;
        out_idx_r    <= {REG_IDX_W{1'b1}};
        out_last_r   <= 1'b1;
        out_is_sum_r <= 1'b1;
      end else if (state_r == IDLE && start) begin
        sum_r <= '0;
      end
`endif
    end
  end

  assign halt_req       = halt_req_r;
  assign rf_addr        = idx_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign dump.out_valid = out_valid_r;
  assign dump.out_data  = out_data_r;
  assign dump.out_idx   = out_idx_r;
  assign dump.out_last  = out_last_r;
`ifdef REG_DUMP_CHECKSUM_EN
  assign dump.out_is_sum = out_is_sum_r;
`endif

endmodule

// File: doc/reg_dump_unit.md
# reg_dump_unit

Debug read-out engine for the single-cycle core's 32×32 register file. On request it halts the core, walks a programmable range of registers through a dedicated read port, and streams each value out on a valid/ready interface. It is the reader-side counterpart of the write-back path and sits between the core's register file and the debug/trace transport.

## Interface
- `NUM_REGS`, default 32: registers in the file.
- `XLEN`, default 32: data width.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `start`  in  1: request a dump; sampled only in IDLE.
- `first_reg`  in  5: first index to dump; sampled with `start`.
- `last_reg`  in  5: last index to dump, inclusive; sampled with `start`.
- `halt_req`  out  1: stall request to the core; keeps the register file stable.
- `halt_ack`  in  1: core is stalled.
- `rf_addr`  out  5: register-file read address, registered.
- `rf_data`  in  XLEN: combinational read data for `rf_addr`.
- `out_valid`  out  1: beat valid.
- `out_ready`  in  1: sink accepts the beat.
- `out_data`  out  XLEN: register value.
- `out_idx`  out  5: register index of the beat.
- `out_last`  out  1: final beat of the dump.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse at completion.

## Operation
- Every output resets to 0.
- State machine IDLE → HALT → READ ⇄ SEND → DONE → IDLE.
- IDLE: `start`=1 with `first_reg` ≤ `last_reg` latches the range, sets `idx`=`first_reg` and goes to HALT. With `first_reg` > `last_reg`, go to DONE: no halt, no beats.
- HALT: `halt_req`=1. Go to READ on the first cycle `halt_ack`=1.
- READ: `rf_addr`=`idx`. At the end of the cycle, capture `rf_data` into `out_data`, `idx` into `out_idx`, and `out_last`=(`idx`==`last`). Go to SEND.
- SEND: `out_valid`=1. `out_data`, `out_idx` and `out_last` stay stable until `out_ready`=1. On transfer, go to DONE if last, otherwise increment `idx` and go to READ.
- DONE: `done`=1 and `halt_req`=0 for one cycle, then go to IDLE.
- `halt_req` is held from HALT through the final SEND.
- `start` is ignored while `busy`=1.
- A `halt_ack` drop mid-dump is not checked; it is the core's contract violation.
- Index arithmetic is 5-bit. `idx` never wraps because the range is checked at start.
- x0 is dumped as read, which is 0.
- `rst_n`=0 mid-dump aborts immediately. All outputs return to 0, `halt_req` drops the next cycle and no `done` pulse is produced.

## Timing
- `start` accepted at edge T: HALT from T+1.
- With `halt_ack` already high and `out_ready` tied high: READ at T+2, first beat transfers at T+3.
- Each further beat takes 2 cycles; beat k transfers at T+3+2k.
- A full 32-register dump has its last beat at T+65, `done` at T+66 and is IDLE at T+67.
- Each cycle of `out_ready`=0 or `halt_ack`=0 adds exactly one cycle.

## Configuration
- `REG_DUMP_CHECKSUM_EN` defined: after the last register beat, emit one extra beat.
  - `out_data` = sum modulo 2^XLEN of all dumped values.
  - `out_idx`=5'd31.
  - New output `out_is_sum` is 1 on this beat only.
  - `out_last` is asserted on the checksum beat, not on the last register beat.
  - An empty range still emits no beats.
- Macro undefined: no checksum beat, no `out_is_sum` port, `out_last` on the last register beat.

## Structure
- Package `reg_dump_pkg` holds:
  - the state enum `dump_state_t` (IDLE, HALT, READ, SEND, DONE; plus SUM under the macro);
  - `REG_IDX_W`=5;
  - the default `NUM_REGS` and `XLEN`.
- Single module; no sub-module. The FSM, index counter, output register and checksum accumulator fit in one body.

## Test plan
- Reset: `rst_n`=0 for 2 cycles → all outputs 0, state IDLE.
- Range 0–31 preloaded with regs[i]=i*0x11, `halt_ack` and `out_ready` tied 1 → 32 beats, beat k carries data 0x11*k and idx k, `out_last` only on idx 31, `done` at T+66.
- Range 5–7 with `out_ready` toggling 1/0 each cycle → 3 beats with data held stable while stalled, `halt_req` dropped in the `done` cycle.
- `halt_ack` delayed 4 cycles → first beat at T+7; `start` pulsed while busy → ignored, no second dump.
- `first_reg`=9, `last_reg`=3 → no `halt_req`, no beats, `done` at T+1.
- Reset asserted during the SEND of reg 2 → `out_valid` and `halt_req` at 0 the next cycle, no `done`. With `REG_DUMP_CHECKSUM_EN`, range 1–2 holding 0xFFFFFFFF and 2 → checksum beat 0x00000001 with `out_is_sum`=1 and `out_last`=1.
